// File: rtl/rgb_stream_packer.sv
// Packs a color-tagged serial R/G/B stream into {R,G,B} words behind a small FIFO.
// Define RGB_PACKER_FLAG_CHECK_EN to compare last_col/last_pic against internal counters.

`ifndef RED
`define RED   2'b00
`endif
`ifndef GREEN
`define GREEN 2'b01
`endif
`ifndef BLUE
`define BLUE  2'b10
`endif
`ifndef VOID
`define VOID  2'b11
`endif

module rgb_stream_packer #(
    parameter int COLOR_DEPTH = 8,
    parameter int IMG_COL     = 1024,
    parameter int IMG_ROW     = 1024,
    parameter int BAND_ROWS   = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COLOR_DEPTH-1:0]   pixel_in,
    input  logic                     valid_in,
    input  logic [1:0]               color_in,
    input  logic                     last_col_in,
    input  logic                     last_pic_in,
    input  logic                     err_clr,
    output logic [3*COLOR_DEPTH-1:0] rgb_data,
    output logic                     rgb_last_band,
    output logic                     rgb_last_pic,
    output logic                     rgb_valid,
    input  logic                     rgb_ready,
    output logic                     frame_done,
    output logic [19:0]              pix_cnt,
    output logic                     err_order,
    output logic                     err_flag,
    output logic                     err_overflow
);
    localparam int PIX_W   = 3 * COLOR_DEPTH;
    localparam int ENTRY_W = PIX_W + 2;
    localparam int AW      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_R, S_G, S_B} state_t;

    state_t                 state;
    logic [COLOR_DEPTH-1:0] r_p0, g_p0;
    logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0]     head;
    logic                   is_red, is_green, is_blue;
    logic                   push_try, push_ok, pop, full, empty, overflow, order_bad;

    assign is_red    = valid_in && (color_in == `RED);
    assign is_green  = valid_in && (color_in == `GREEN);
    assign is_blue   = valid_in && (color_in == `BLUE);
    assign push_try  = is_blue && (state == S_B);
    assign order_bad = valid_in && !((state == S_R && is_red) ||
                                     (state == S_G && is_green) ||
                                     (state == S_B && is_blue));

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && rgb_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
    assign push_ok  = push_try && (!full || pop);
    assign overflow = push_try && full && !pop;

    assign head          = mem[rd_ptr[AW-1:0]];
    assign rgb_valid     = !empty;
    assign rgb_data      = rgb_valid ? head[ENTRY_W-1:2] : '0;
    assign rgb_last_band = rgb_valid && head[1];
    assign rgb_last_pic  = rgb_valid && head[0];

    // Datapath registers: no reset, their contents are only observed through valid control.
    always_ff @(posedge clk) begin
        if (is_red)
            r_p0 <= pixel_in;
        if (is_green && state == S_G)
            g_p0 <= pixel_in;
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= {r_p0, g_p0, pixel_in, last_col_in, last_pic_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_R;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pix_cnt      <= '0;
            frame_done   <= 1'b0;
            err_order    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            // RED always restarts a triplet, so a stray RED resynchronises the stream.
            if (valid_in) begin
                if (is_red)
                    state <= S_G;
                else if (state == S_G && is_green)
                    state <= S_B;
                else
                    state <= S_R;
            end
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_try)
                pix_cnt <= last_pic_in ? '0 : pix_cnt + 1'b1;
            frame_done   <= push_try && last_pic_in;
            err_order    <= order_bad || (err_order && !err_clr);
            err_overflow <= overflow  || (err_overflow && !err_clr);
        end
    end

`ifdef RGB_PACKER_FLAG_CHECK_EN
    localparam int              BAND_LEN   = IMG_COL * BAND_ROWS;
    localparam int              BAND_W     = $clog2(BAND_LEN + 1);
    localparam logic [BAND_W-1:0] BAND_LAST  = BAND_W'(BAND_LEN - 1);
    localparam logic [19:0]     FRAME_LAST = 20'(IMG_COL * IMG_ROW - 1);

    // band_cnt tracks pix_cnt mod BAND_LEN without a divider.
    logic [BAND_W-1:0] band_cnt;
    logic              flag_bad;

    assign flag_bad = push_try && ((last_col_in != (band_cnt == BAND_LAST)) ||
                                   (last_pic_in != (pix_cnt == FRAME_LAST)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            band_cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            if (push_try)
                band_cnt <= (last_pic_in || band_cnt == BAND_LAST) ? '0 : band_cnt + 1'b1;
            err_flag <= flag_bad || (err_flag && !err_clr);
        end
    end
`else
    assign err_flag = 1'b0;
`endif

endmodule

// File: doc/rgb_stream_packer.md
Name: rgb_stream_packer

Overview:
- Receive side of the color-tagged serial pixel stream that the ISP top emits: pixel_out, valid_out, color_out, last_col_out, last_pic_out.
- Collects R, G, B beats into one 3×COLOR_DEPTH word and checks beat order and the last_col/last_pic framing flags against internal counters.
- Buffers packed pixels in a small FIFO behind a valid/ready handshake.
- Sits between the ISP top output and the frame-store/DMA writer.

Parameters:
- COLOR_DEPTH, 8, bits per color sample.
- IMG_COL, 1024, pixels per image row.
- IMG_ROW, 1024, rows per frame.
- BAND_ROWS, 4, rows per band; last_col marks the last pixel of each band.
- FIFO_DEPTH, 4, packed-pixel FIFO entries (power of two, ≥2).

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- pixel_in, in, COLOR_DEPTH, serial sample.
- valid_in, in, 1, sample valid; no backpressure upstream.
- color_in, in, 2, `RED/`GREEN/`BLUE/`VOID code from define.v.
- last_col_in, in, 1, band-end flag, sampled on the BLUE beat only.
- last_pic_in, in, 1, frame-end flag, sampled on the BLUE beat only.
- err_clr, in, 1, clears all sticky error flags.
- rgb_data, out, 3*COLOR_DEPTH, {R,G,B}, R in the MSBs.
- rgb_last_band, out, 1, band-end flag of the head entry.
- rgb_last_pic, out, 1, frame-end flag of the head entry.
- rgb_valid, out, 1, FIFO head valid.
- rgb_ready, in, 1, downstream accepts the head entry.
- frame_done, out, 1, one-cycle pulse after the frame-end BLUE beat.
- pix_cnt, out, 20, packed pixels accepted in the current frame.
- err_order, out, 1, sticky: VOID or out-of-order color.
- err_flag, out, 1, sticky: last_col/last_pic mismatch.
- err_overflow, out, 1, sticky: packed pixel dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in S_R, pix_cnt 0.
- FSM states: S_R (expect RED), S_G (expect GREEN), S_B (expect BLUE). A beat is any cycle with valid_in=1.
- S_R, RED: latch r, go to S_G.
- S_G, GREEN: latch g, go to S_B.
- S_B, BLUE: form pixel {r,g,b,last_col_in,last_pic_in}, push to FIFO, go to S_R.
- Wrong color in S_G/S_B when the color is RED: set err_order, latch r, go to S_G (resync).
- Any other wrong color, including VOID in any state: set err_order, drop the beat, go to S_R.
- valid_in=0: hold state, no side effects.
- Counters on each BLUE push attempt, whether or not it overflows:
  - Expected last_col = (pix_cnt mod (IMG_COL*BAND_ROWS)) == IMG_COL*BAND_ROWS-1.
  - Expected last_pic = pix_cnt == IMG_COL*IMG_ROW-1.
  - Either mismatch sets err_flag.
- Frame end: if last_pic_in=1 on the BLUE beat, pix_cnt goes to 0 and frame_done pulses next cycle. Otherwise pix_cnt increments.
- FIFO behaviour:
  - Push on the BLUE beat; rgb_valid rises the cycle after the push (latency 1).
  - Pop when rgb_valid && rgb_ready.
  - Simultaneous push and pop on a full FIFO succeeds, with no overflow.
  - Push while full without a pop: drop the pixel, set err_overflow.
  - rgb_* outputs stay stable while rgb_valid && !rgb_ready.
- Sticky errors: cleared by err_clr the next cycle. If a new error and err_clr occur in the same cycle, the error wins.
- Reset mid-triplet or mid-frame: partial triplet discarded, FIFO flushed, counters zeroed.

Optional Feature:
- Macro: RGB_PACKER_FLAG_CHECK_EN.
- Defined: counters and err_flag checking as above.
- Undefined: err_flag tied to 0 and the expected-flag compare logic is removed.
- Unaffected in both cases: pix_cnt, frame_done and flag pass-through.

Test Plan:
- Stream 8 pixels R=0x10+i, G=0x20+i, B=0x30+i, IMG_COL=2, BAND_ROWS=1, IMG_ROW=4, rgb_ready=1 → eight words 0x102030..0x172737 are output.
  - rgb_last_band set on pixels 2, 4, 6, 8.
  - rgb_last_pic set on pixel 8; frame_done pulses once.
  - All error flags remain 0.
- Beats RED 0x11, BLUE 0x33, RED 0x44, GREEN 0x55, BLUE 0x66 → err_order=1; exactly one word 0x445566 is output.
- Beats RED, GREEN, RED 0xAA, GREEN 0xBB, BLUE 0xCC → err_order=1 (resync on RED); one word 0xAABBCC is output.
- rgb_ready=0, push 5 pixels with FIFO_DEPTH=4 → err_overflow=1, FIFO holds the first 4 pixels. Then rgb_ready=1 → those 4 pixels drain in order.
- last_pic_in=1 on pixel 3 with IMG_COL*IMG_ROW=8:
  - Flag check compiled in → err_flag=1, pix_cnt returns to 0.
  - Flag check compiled out → err_flag stays 0.
- Assert rst mid-frame after the GREEN beat → all outputs 0 immediately. The next full triplet then packs correctly with pix_cnt=1.
